msdf_ram_sequencer: RTL and testbench

- Arithmetic-side controller for the HPS-shared dual-port RAM; drives the arith port's addr_arith, data_arith and we_arith, and reads q_arith.
- On start, streams N operand pairs from RAM into an MSDF datapath (e.g. the adder) over a valid/ready handshake.
- Writes each result back to RAM, then flags done so HPS software can read the results.
- Sits between port B of the RAM and the arithmetic core, all on ram_clock.

---
 rtl/msdf_seq_pkg.sv | 25 ++
 rtl/msdf_seq_timeout.sv | 30 +++
 rtl/msdf_ram_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_msdf_ram_sequencer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msdf_seq_pkg.sv
// Shared types and defaults for the MSDF RAM sequencers: state encoding,
// word/address widths, timeout default and a counter-width helper.
package msdf_seq_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 11;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned TIMEOUT_DEF    = 1024;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP_B,
    ISSUE,
    WAIT_RES,
    WRITE,
    DONE
  } seq_state_e;

  // Bits needed to hold the value n itself (never less than one).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/msdf_seq_timeout.sv
// Loadable down-counter: load the limit, then expire_o fires on the enabled
// cycle in which the count reaches its final tick.
module msdf_seq_timeout #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/msdf_ram_sequencer.sv
// Arithmetic-side RAM sequencer: streams operand pairs from port B into an
// MSDF datapath and writes results back. Optional run cycle counter is
// enabled by defining MSDF_SEQ_CYCLE_COUNT_EN.
module msdf_ram_sequencer
  import msdf_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  ram_clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [ADDR_WIDTH-1:0] base_r,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] addr_arith,
  output logic [DATA_WIDTH-1:0] data_arith,
  output logic                  we_arith,
  input  logic [DATA_WIDTH-1:0] q_arith,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic                  op_valid,
  input  logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] res,
  input  logic                  res_valid,
  output logic [31:0]           cycles
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned TW = cnt_width(TIMEOUT);

  seq_state_e            state_q, state_d;
  logic [CW-1:0]         idx_q, idx_d, count_q, count_d, idx_next;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d, base_b_q, base_b_d, base_r_q, base_r_d;
  logic [ADDR_WIDTH-1:0] idx_addr;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  accept, tmo_load, tmo_en, tmo_expire;

  assign accept   = start && ((state_q == IDLE) || (state_q == DONE));
  assign idx_addr = idx_q[ADDR_WIDTH-1:0];
  assign idx_next = idx_q + CW'(1);

  // NOTE: asynchronous reset clears every register here; there is no storage
  // array in this block, so nothing is left unreset.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      count_q  <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_r_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_r_q <= base_r_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      res_q    <= res_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // NOTE: every signal written below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    base_a_d   = base_a_q;
    base_b_d   = base_b_q;
    base_r_d   = base_r_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_d      = res_q;
    done_d     = done_q;
    err_d      = err_q;
    addr_arith = '0;
    we_arith   = 1'b0;
    op_valid   = 1'b0;
    tmo_load   = 1'b0;
    tmo_en     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          base_a_d = base_a;
          base_b_d = base_b;
          base_r_d = base_r;
          count_d  = count;
          idx_d    = '0;
          err_d    = 1'b0;
          done_d   = (count == '0);
          state_d  = (count == '0) ? DONE : RD_A;
        end
      end
      RD_A: begin
        addr_arith = base_a_q + idx_addr;
        state_d    = RD_B;
      end
      RD_B: begin
        addr_arith = base_b_q + idx_addr;
        op_a_d     = q_arith;
        state_d    = CAP_B;
      end
      CAP_B: begin
        op_b_d  = q_arith;
        state_d = ISSUE;
      end
      ISSUE: begin
        op_valid = 1'b1;
        if (op_ready) begin
          tmo_load = 1'b1;
          state_d  = WAIT_RES;
        end
      end
      WAIT_RES: begin
        tmo_en = 1'b1;
        // A result arriving on the last allowed cycle still wins over the abort.
        if (res_valid) begin
          res_d   = res;
          state_d = WRITE;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        addr_arith = base_r_q + idx_addr;
        we_arith   = 1'b1;
        idx_d      = idx_next;
        if (idx_next == count_q) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RD_A;
        end
      end
    endcase
  end

  if (TIMEOUT != 0) begin : g_tmo
    msdf_seq_timeout #(.WIDTH(TW)) u_tmo (
      .clk       (ram_clock),
      .rst_n     (resetn),
      .load_i    (tmo_load),
      .load_val_i(TW'(TIMEOUT)),
      .en_i      (tmo_en),
      .expire_o  (tmo_expire)
    );
  end else begin : g_no_tmo
    assign tmo_expire = 1'b0;
  end

  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = done_q;
  assign err        = err_q;
  assign data_arith = res_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;

`ifdef MSDF_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycles_q, cycles_d;

  // The accept cycle counts as the first busy cycle of the run.
  always_comb begin
    cycles_d = cycles_q;
    if (accept) begin
      cycles_d = 32'd1;
    end else if (busy && (cycles_q != 32'hFFFF_FFFF)) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      cycles_q <= '0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

  assign cycles = cycles_q;
`else
  assign cycles = '0;
`endif

endmodule

// File: tb/tb_msdf_ram_sequencer.sv
// Self-checking bench: RAM model, add-datapath stub and a sequential
// reference model of the vector add, with randomized jobs.
module tb_msdf_ram_sequencer;

  localparam int N   = 2048;
  localparam int TMO = 8;

  logic        ram_clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [10:0] base_a = '0, base_b = '0, base_r = '0;
  logic [11:0] count = '0;
  logic        busy, done, err, we_arith, op_valid, op_ready, res_valid;
  logic [10:0] addr_arith;
  logic [31:0] data_arith, q_arith, op_a, op_b, res, cycles;

  msdf_ram_sequencer #(.TIMEOUT(TMO)) dut (
    .ram_clock (ram_clock), .resetn(resetn), .start(start),
    .base_a    (base_a), .base_b(base_b), .base_r(base_r), .count(count),
    .busy      (busy), .done(done), .err(err),
    .addr_arith(addr_arith), .data_arith(data_arith), .we_arith(we_arith),
    .q_arith   (q_arith), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .op_ready  (op_ready), .res(res), .res_valid(res_valid), .cycles(cycles)
  );

  always #5 ram_clock = ~ram_clock;

  // RAM model: HPS-side fill/write plus the sequencer's port B.
  logic [31:0] mem [N];
  logic        fill_rand = 1'b0, hps_we = 1'b0;
  logic [10:0] hps_addr = '0;
  logic [31:0] hps_data = '0;

  always @(posedge ram_clock) begin
    if (fill_rand) begin
      for (int k = 0; k < N; k++) mem[k] <= $urandom;
    end else if (hps_we) begin
      mem[hps_addr] <= hps_data;
    end else if (we_arith) begin
      mem[addr_arith] <= data_arith;
    end
    q_arith <= mem[addr_arith];
  end

  // Add-datapath stub with programmable latency and optional junk strobes.
  logic ready_fix = 1'b1, ready_rand = 1'b0, rnd_ready = 1'b1;
  logic dp_en = 1'b1, noise_en = 1'b0, noise_q = 1'b0;
  int   lat = 2;
  int   cnt = 0;
  logic [31:0] sum = '0;

  assign op_ready  = ready_rand ? rnd_ready : ready_fix;
  assign res_valid = dp_en && ((cnt == 1) || ((cnt == 0) && noise_q));
  assign res       = (cnt == 1) ? sum : 32'hDEAD_BEEF;

  always @(negedge ram_clock) begin
    noise_q   <= noise_en && ($urandom_range(3) == 0);
    rnd_ready <= ($urandom_range(1) == 1);
  end

  always @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= 0;
    end else if (op_valid && op_ready) begin
      cnt <= lat;
      sum <= op_a + op_b;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  // Transaction logs.
  int          wr_n = 0, xfer_n = 0, opv_n = 0;
  logic [10:0] wr_addr_log [4096];
  logic [31:0] wr_data_log [4096];
  logic [31:0] xa_log [4096], xb_log [4096];

  always @(posedge ram_clock) begin
    if (we_arith) begin
      wr_addr_log[wr_n & 4095] <= addr_arith;
      wr_data_log[wr_n & 4095] <= data_arith;
      wr_n <= wr_n + 1;
    end
    if (op_valid) opv_n <= opv_n + 1;
    if (op_valid && op_ready) begin
      xa_log[xfer_n & 4095] <= op_a;
      xb_log[xfer_n & 4095] <= op_b;
      xfer_n <= xfer_n + 1;
    end
  end

  // Reference model state.
  int          checks = 0, errors = 0;
  logic [31:0] exp_mem [N];
  logic [31:0] exp_a [64], exp_b [64];
  int          exp_waddr [64];
  int          exp_n = 0, w0 = 0, x0 = 0;
  int          j_ba = 0, j_bb = 0, j_br = 0, j_cnt = 0;

  task automatic prep_job(input int ba, input int bb, input int br, input int c);
    j_ba = ba; j_bb = bb; j_br = br; j_cnt = c;
    for (int k = 0; k < N; k++) exp_mem[k] = mem[k];
    for (int i = 0; i < c; i++) begin
      exp_a[i]     = exp_mem[(ba + i) % N];
      exp_b[i]     = exp_mem[(bb + i) % N];
      exp_waddr[i] = (br + i) % N;
      exp_mem[exp_waddr[i]] = exp_a[i] + exp_b[i];
    end
    exp_n = c; w0 = wr_n; x0 = xfer_n;
  endtask

  task automatic start_job();
    @(negedge ram_clock);
    base_a = 11'(j_ba); base_b = 11'(j_bb); base_r = 11'(j_br);
    count  = 12'(j_cnt);
    start  = 1'b1;
    @(negedge ram_clock);
    start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int n = 0; n < 3000 && !(done && !busy); n++) @(negedge ram_clock);
    checks++;
    if (!(done === 1'b1 && busy === 1'b0)) begin
      errors++;
      $display("FAIL %s wait_done: timed out, done=%b busy=%b, expected done=1 busy=0", name, done, busy);
    end
  endtask

  task automatic check_job(input string name);
    int bad;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s flags: done=%b busy=%b err=%b, expected 1/0/0", name, done, busy, err);
    end
    checks++;
    if (wr_n - w0 !== exp_n || xfer_n - x0 !== exp_n) begin
      errors++;
      $display("FAIL %s counts: writes=%0d transfers=%0d, expected %0d each", name, wr_n - w0, xfer_n - x0, exp_n);
    end
    bad = -1;
    for (int i = 0; i < exp_n; i++)
      if (bad < 0 && (int'(wr_addr_log[(w0 + i) & 4095]) !== exp_waddr[i] ||
                      wr_data_log[(w0 + i) & 4095] !== exp_a[i] + exp_b[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s write[%0d]: addr=%0d data=%h, expected addr=%0d data=%h", name, bad,
               wr_addr_log[(w0 + bad) & 4095], wr_data_log[(w0 + bad) & 4095],
               exp_waddr[bad], exp_a[bad] + exp_b[bad]);
    end
    bad = -1;
    for (int i = 0; i < exp_n; i++)
      if (bad < 0 && (xa_log[(x0 + i) & 4095] !== exp_a[i] || xb_log[(x0 + i) & 4095] !== exp_b[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s operands[%0d]: a=%h b=%h, expected a=%h b=%h", name, bad,
               xa_log[(x0 + bad) & 4095], xb_log[(x0 + bad) & 4095], exp_a[bad], exp_b[bad]);
    end
    bad = -1;
    for (int k = 0; k < N; k++) if (bad < 0 && mem[k] !== exp_mem[k]) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s ram[%0d]: got %h, expected %h", name, bad, mem[bad], exp_mem[bad]);
    end
  endtask

  task automatic fill_mem();
    @(negedge ram_clock); fill_rand = 1'b1;
    @(negedge ram_clock); fill_rand = 1'b0;
  endtask

  task automatic hps_write(input int a, input logic [31:0] d);
    @(negedge ram_clock); hps_we = 1'b1; hps_addr = 11'(a); hps_data = d;
    @(negedge ram_clock); hps_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ram_clock);
    checks++;
    if ({busy, done, err, we_arith, op_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset flags: busy/done/err/we/op_valid=%b, expected 00000", {busy, done, err, we_arith, op_valid});
    end
    checks++;
    if (addr_arith !== '0 || data_arith !== '0 || op_a !== '0 || op_b !== '0 || cycles !== '0) begin
      errors++;
      $display("FAIL reset buses: addr=%h data=%h op_a=%h op_b=%h cycles=%0d, expected all 0",
               addr_arith, data_arith, op_a, op_b, cycles);
    end
    resetn = 1'b1;
  endtask

  task automatic test_count_zero();
    int o0;
    prep_job(5, 6, 7, 0);
    o0 = opv_n;
    start_job();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL count_zero one cycle after start: done=%b busy=%b, expected done=1 busy=0", done, busy);
    end
    repeat (4) @(negedge ram_clock);
    checks++;
    if (wr_n !== w0 || opv_n !== o0 || err !== 1'b0) begin
      errors++;
      $display("FAIL count_zero activity: writes=%0d op_valid cycles=%0d err=%b, expected 0/0/0", wr_n - w0, opv_n - o0, err);
    end
  endtask

  task automatic test_directed_add();
    logic [31:0] want [4];
    want = '{32'd11, 32'd22, 32'd33, 32'd44};
    fill_mem();
    for (int i = 0; i < 4; i++) begin
      hps_write(i, 32'(i + 1));
      hps_write(16 + i, 32'(10 * (i + 1)));
    end
    lat = 2;
    prep_job(0, 16, 32, 4);
    start_job();
    wait_done("directed");
    check_job("directed");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[32 + i] !== want[i]) begin
        errors++;
        $display("FAIL directed ram[%0d]: got %0d, expected %0d", 32 + i, mem[32 + i], want[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] sa, sb;
    logic        stable;
    int          n;
    ready_fix = 1'b0;
    lat = 3;
    prep_job($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 1);
    start_job();
    for (n = 0; n < 50 && !op_valid; n++) @(negedge ram_clock);
    checks++;
    if (op_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall: op_valid=%b after %0d cycles, expected 1", op_valid, n);
    end
    sa = op_a; sb = op_b; stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      // A start while busy, with new parameters, must be ignored.
      start = (c == 2); count = '0; base_a = ~base_a;
      @(negedge ram_clock);
      if (op_valid !== 1'b1 || op_a !== sa || op_b !== sb || xfer_n !== x0) stable = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL stall hold: op_valid=%b op_a=%h op_b=%h, expected 1 %h %h", op_valid, op_a, op_b, sa, sb);
    end
    ready_fix = 1'b1;
    wait_done("stall");
    check_job("stall");
  endtask

  task automatic test_wrap();
    lat = 2;
    prep_job(2046, 0, 2047, 3);
    start_job();
    wait_done("wrap");
    check_job("wrap");
    checks++;
    if (wr_addr_log[w0 & 4095] !== 11'd2047 || wr_addr_log[(w0 + 1) & 4095] !== 11'd0 ||
        wr_addr_log[(w0 + 2) & 4095] !== 11'd1) begin
      errors++;
      $display("FAIL wrap write addrs: %0d %0d %0d, expected 2047 0 1", wr_addr_log[w0 & 4095],
               wr_addr_log[(w0 + 1) & 4095], wr_addr_log[(w0 + 2) & 4095]);
    end
  endtask

  task automatic test_timeout();
    int n;
    dp_en = 1'b0;
    prep_job($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 2);
    start_job();
    for (n = 0; n < 50 && !op_valid; n++) @(negedge ram_clock);
    // The transfer happens on the next edge; done is first visible at the
    // negedge after the edge that ends the TMO-th WAIT_RES cycle.
    n = 0;
    while (n < 50 && !done) begin
      @(negedge ram_clock);
      n++;
    end
    checks++;
    if (n !== TMO + 1) begin
      errors++;
      $display("FAIL timeout latency: done seen %0d cycles after issue, expected %0d", n, TMO + 1);
    end
    checks++;
    if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || wr_n !== w0 || xfer_n - x0 !== 1) begin
      errors++;
      $display("FAIL timeout state: err=%b done=%b busy=%b writes=%0d transfers=%0d, expected 1 1 0 0 1",
               err, done, busy, wr_n - w0, xfer_n - x0);
    end
    dp_en = 1'b1;
    prep_job($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 1);
    start_job();
    checks++;
    if (err !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout restart: err=%b done=%b busy=%b, expected 0 0 1", err, done, busy);
    end
    wait_done("timeout_rerun");
    check_job("timeout_rerun");
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 2;
    prep_job($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 4);
    start_job();
    for (n = 0; n < 200 && (xfer_n - x0) < 3; n++) @(negedge ram_clock);
    checks++;
    if (xfer_n - x0 !== 3) begin
      errors++;
      $display("FAIL reset_mid reach element 2: transfers=%0d, expected 3", xfer_n - x0);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, we_arith, op_valid} !== 5'b0 || addr_arith !== '0 || data_arith !== '0 ||
        op_a !== '0 || op_b !== '0 || cycles !== '0) begin
      errors++;
      $display("FAIL reset_mid async: flags=%b addr=%h data=%h op_a=%h op_b=%h cycles=%0d, expected all 0",
               {busy, done, err, we_arith, op_valid}, addr_arith, data_arith, op_a, op_b, cycles);
    end
    @(negedge ram_clock);
    resetn = 1'b1;
    repeat (2) @(negedge ram_clock);
    checks++;
    if ({busy, done, we_arith, op_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid idle: busy/done/we/op_valid=%b, expected 0000", {busy, done, we_arith, op_valid});
    end
    prep_job(j_ba, j_bb, j_br, 4);
    start_job();
    wait_done("reset_mid_rerun");
    check_job("reset_mid_rerun");
  endtask

  task automatic test_cycles();
    logic [31:0] want;
`ifdef MSDF_SEQ_CYCLE_COUNT_EN
    want = 32'd25;
`else
    want = 32'd0;
`endif
    lat = 1;
    prep_job($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1), 4);
    start_job();
    wait_done("cycles");
    check_job("cycles");
    repeat (3) @(negedge ram_clock);
    checks++;
    if (cycles !== want) begin
      errors++;
      $display("FAIL cycles: got %0d, expected %0d", cycles, want);
    end
  endtask

  task automatic test_back_to_back();
    ready_rand = 1'b1;
    noise_en   = 1'b1;
    for (int r = 0; r < 6; r++) begin
      lat = $urandom_range(1, 4);
      prep_job($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
               $urandom_range(1, 24));
      start_job();
      wait_done("random");
      check_job("random");
    end
    ready_rand = 1'b0;
    noise_en   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_zero();
    test_directed_add();
    test_stall();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_cycles();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
